// File: rtl/xg_lsu_if.sv
// Signal bundle between the EX stage, the LSU, the data-memory bus and write-back.
// The slave modport is the LSU's view; master is the surrounding pipeline/bus.
interface xg_lsu_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [RD_W-1:0] req_rd;
  logic            flush_i;
  logic            stall_o;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_wstrb;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;
  logic            wb_valid;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            fault_o;
  logic [1:0]      fault_cause;
  logic [XLEN-1:0] fault_addr;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, flush_i,
           dmem_ack, dmem_rdata,
    output req_ready, stall_o, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
           wb_valid, wb_rd, wb_data, fault_o, fault_cause, fault_addr
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, flush_i,
           dmem_ack, dmem_rdata,
    input  req_ready, stall_o, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
           wb_valid, wb_rd, wb_data, fault_o, fault_cause, fault_addr
  );
endinterface

// File: rtl/xg_lsu_stage.sv
// Memory-access stage: one data-memory transaction per accepted load/store,
// with load alignment/extension and rejection of illegal or misaligned accesses.
module xg_lsu_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input logic     clk,
  input logic     rstn,
  xg_lsu_if.slave lsu
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RESP  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic            flushed_p1, flushed_nxt;
  logic            accept;
  logic            illegal_p0, misal_p0;
  logic [1:0]      cause_p0;

  logic [XLEN-1:0] addr_p1, wdata_p1;
  logic [2:0]      f3_p1;
  logic            we_p1;
  logic [RD_W-1:0] rd_p1;
  logic [1:0]      cause_p1;
  logic [XLEN-1:0] rdata_p2;

  function automatic logic [XLEN-1:0] load_align(input logic [XLEN-1:0] word,
                                                 input logic [1:0] ofs,
                                                 input logic [2:0] f3);
    logic [XLEN-1:0]        sh;
    logic signed [7:0]      b;
    logic signed [15:0]     h;
    logic signed [XLEN-1:0] ext;
    sh = word >> {ofs, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'd0:    ext = b;
      3'd1:    ext = h;
      3'd4:    ext = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'd5:    ext = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: ext = sh;
    endcase
    return ext;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] ofs);
    logic [3:0] s;
    case (f3[1:0])
      2'd0:    s = 4'b0001;
      2'd1:    s = 4'b0011;
      default: s = 4'b1111;
    endcase
    return s << ofs;
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3,
                                                 input logic [XLEN-1:0] d);
    case (f3[1:0])
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Stage p0: classify the incoming request; illegal funct3 wins over misalignment
  always_comb begin
    illegal_p0 = lsu.req_we ? (lsu.req_funct3 > 3'd2)
                            : (lsu.req_funct3 == 3'd3 || lsu.req_funct3 > 3'd5);
    case (lsu.req_funct3[1:0])
      2'd1:    misal_p0 = lsu.req_addr[0];
      2'd2:    misal_p0 = |lsu.req_addr[1:0];
      default: misal_p0 = 1'b0;
    endcase
    if (illegal_p0)    cause_p0 = 2'b11;
    else if (misal_p0) cause_p0 = lsu.req_we ? 2'b10 : 2'b01;
    else               cause_p0 = 2'b00;
  end

  assign accept = lsu.req_valid & (state == S_IDLE) & ~lsu.flush_i;

  always_comb begin
    state_nxt   = state;
    flushed_nxt = flushed_p1;
    case (state)
      S_IDLE: begin
        if (accept) begin
          flushed_nxt = 1'b0;
          state_nxt   = (cause_p0 != 2'b00) ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        // A flush cannot abort the bus cycle; it only kills the later write-back
        if (lsu.flush_i) flushed_nxt = 1'b1;
        if (lsu.dmem_ack) state_nxt = S_RESP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      flushed_p1 <= 1'b0;
    end else begin
      state      <= state_nxt;
      flushed_p1 <= flushed_nxt;
    end
  end

  // Stage p1/p2: request held for the bus, aligned load data captured on ack
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= lsu.req_addr;
      wdata_p1 <= lsu.req_wdata;
      f3_p1    <= lsu.req_funct3;
      we_p1    <= lsu.req_we;
      rd_p1    <= lsu.req_rd;
      cause_p1 <= cause_p0;
    end
    if (state == S_REQ && lsu.dmem_ack)
      rdata_p2 <= load_align(lsu.dmem_rdata, addr_p1[1:0], f3_p1);
  end

  // Outputs are qualified by state so that reset forces them to zero at once
  assign lsu.req_ready   = (state == S_IDLE);
  assign lsu.stall_o     = ((state == S_IDLE) & lsu.req_valid & ~lsu.flush_i) | (state == S_REQ);
  assign lsu.dmem_req    = (state == S_REQ);
  assign lsu.dmem_we     = (state == S_REQ) & we_p1;
  assign lsu.dmem_addr   = (state == S_REQ) ? {addr_p1[XLEN-1:2], 2'b00} : '0;
  assign lsu.dmem_wstrb  = lsu.dmem_we ? store_strb(f3_p1, addr_p1[1:0]) : 4'b0000;
  assign lsu.dmem_wdata  = lsu.dmem_we ? store_data(f3_p1, wdata_p1) : '0;
  assign lsu.wb_valid    = (state == S_RESP) & ~we_p1 & ~flushed_p1 & ~lsu.flush_i;
  assign lsu.wb_rd       = lsu.wb_valid ? rd_p1 : '0;
  assign lsu.wb_data     = lsu.wb_valid ? rdata_p2 : '0;
  assign lsu.fault_o     = (state == S_FAULT) & ~lsu.flush_i;
  assign lsu.fault_cause = lsu.fault_o ? cause_p1 : 2'b00;
  assign lsu.fault_addr  = lsu.fault_o ? addr_p1 : '0;

endmodule

// File: tb/tb_xg_lsu_stage.sv
// Directed plus randomized bench for xg_lsu_stage against a byte-level reference model.
module tb_xg_lsu_stage;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  xg_lsu_if #(.XLEN(32), .RD_W(5)) bus ();
  xg_lsu_stage #(.XLEN(32), .RD_W(5)) dut (.clk(clk), .rstn(rstn), .lsu(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes and byte offset, plain arithmetic
  function automatic logic [1:0] m_cause(input bit we, input int f3, input logic [31:0] a);
    int size;
    int ofs;
    if (we ? (f3 > 2) : (f3 == 3 || f3 == 6 || f3 == 7)) return 2'b11;
    size = 1 << (f3 % 4);
    ofs  = int'(a % 4);
    if (ofs % size != 0) return we ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] w;
    w = rd >> (8 * int'(a % 4));
    case (f3)
      0: return (w & 32'hFF)   | ((w & 32'h80)   != 0 ? 32'hFFFFFF00 : 32'h0);
      1: return (w & 32'hFFFF) | ((w & 32'h8000) != 0 ? 32'hFFFF0000 : 32'h0);
      4: return w & 32'hFF;
      5: return w & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_strb(input int f3, input logic [31:0] a);
    int size;
    size = 1 << (f3 % 4);
    return ((32'd1 << size) - 32'd1) << int'(a % 4);
  endfunction

  function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] d);
    case (f3)
      0: return (d & 32'hFF) * 32'h01010101;
      1: return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, ".req_ready"}, bus.req_ready, 1);
    chk({tag, ".stall_o"}, bus.stall_o, 0);
    chk({tag, ".dmem_req"}, bus.dmem_req, 0);
    chk({tag, ".dmem_we"}, bus.dmem_we, 0);
    chk({tag, ".dmem_addr"}, bus.dmem_addr, 0);
    chk({tag, ".dmem_wstrb"}, bus.dmem_wstrb, 0);
    chk({tag, ".dmem_wdata"}, bus.dmem_wdata, 0);
    chk({tag, ".wb_valid"}, bus.wb_valid, 0);
    chk({tag, ".wb_rd"}, bus.wb_rd, 0);
    chk({tag, ".wb_data"}, bus.wb_data, 0);
    chk({tag, ".fault_o"}, bus.fault_o, 0);
    chk({tag, ".fault_cause"}, bus.fault_cause, 0);
    chk({tag, ".fault_addr"}, bus.fault_addr, 0);
  endtask

  // Called just after a rising edge with the DUT idle; returns just after a rising edge, idle again.
  task automatic run_txn(input string tag, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                         input int k, input bit flush_req, input logic [4:0] rd);
    logic [1:0] cause;
    bit         load_wb;
    cause = m_cause(we, int'(f3), a);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
    @(negedge clk);
    chk({tag, ".ready"}, bus.req_ready, 1);
    chk({tag, ".stall_T"}, bus.stall_o, 1);
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_funct3 = 3'($urandom);
    bus.req_we     = 1'($urandom);
    bus.req_rd     = 5'($urandom);
    if (cause != 2'b00) begin
      @(negedge clk);
      chk({tag, ".fault_o"}, bus.fault_o, 1);
      chk({tag, ".fault_cause"}, bus.fault_cause, cause);
      chk({tag, ".fault_addr"}, bus.fault_addr, a);
      chk({tag, ".fault_nobus"}, bus.dmem_req, 0);
      chk({tag, ".fault_stall"}, bus.stall_o, 0);
      chk({tag, ".fault_wb"}, bus.wb_valid, 0);
      @(posedge clk); #1;
    end else begin
      for (int i = 1; i <= k; i++) begin
        bus.dmem_ack   = (i == k);
        bus.dmem_rdata = (i == k) ? rdv : $urandom;
        bus.flush_i    = flush_req && (i == 1);
        @(negedge clk);
        chk({tag, ".dmem_req"}, bus.dmem_req, 1);
        chk({tag, ".dmem_we"}, bus.dmem_we, we);
        chk({tag, ".dmem_addr"}, bus.dmem_addr, {a[31:2], 2'b00});
        chk({tag, ".stall_req"}, bus.stall_o, 1);
        chk({tag, ".ready_req"}, bus.req_ready, 0);
        chk({tag, ".wstrb"}, bus.dmem_wstrb, we ? m_strb(int'(f3), a) : 32'h0);
        if (we) chk({tag, ".wdata"}, bus.dmem_wdata, m_wdata(int'(f3), wd));
        @(posedge clk); #1;
      end
      bus.dmem_ack   = 1'b0;
      bus.flush_i    = 1'b0;
      bus.dmem_rdata = $urandom;
      load_wb = !we && !flush_req;
      @(negedge clk);
      chk({tag, ".wb_valid"}, bus.wb_valid, load_wb);
      if (load_wb) begin
        chk({tag, ".wb_data"}, bus.wb_data, m_load(int'(f3), a, rdv));
        chk({tag, ".wb_rd"}, bus.wb_rd, rd);
      end
      chk({tag, ".resp_stall"}, bus.stall_o, 0);
      chk({tag, ".resp_nobus"}, bus.dmem_req, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_rd     = 5'd0;
    bus.flush_i    = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    run_txn("lw_100",  1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b0, 5'd7);
    run_txn("lb_103",  1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b0, 5'd1);
    run_txn("lbu_103", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 2, 1'b0, 5'd2);
    run_txn("lh_102",  1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF0000, 1, 1'b0, 5'd3);
    run_txn("sb_201",  1'b1, 3'd0, 32'h201, 32'h12345678, 32'h0, 2, 1'b0, 5'd0);
    run_txn("sh_302",  1'b1, 3'd1, 32'h302, 32'hCAFEBABE, 32'h0, 1, 1'b0, 5'd0);
    run_txn("lw_mis",  1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 1, 1'b0, 5'd4);
    run_txn("ld_ill",  1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1, 1'b0, 5'd5);
    run_txn("sh_mis",  1'b1, 3'd1, 32'h301, 32'h0, 32'h0, 1, 1'b0, 5'd0);
    run_txn("lw_flush", 1'b0, 3'd2, 32'h180, 32'h0, 32'h11223344, 2, 1'b1, 5'd9);

    // Flush in IDLE must block the accept entirely
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h400;
    bus.flush_i    = 1'b1;
    @(negedge clk);
    chk("flush_idle.stall", bus.stall_o, 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.flush_i   = 1'b0;
    @(negedge clk);
    chk("flush_idle.no_req", bus.dmem_req, 0);
    chk("flush_idle.ready", bus.req_ready, 1);
    @(posedge clk); #1;

    // Asynchronous reset while the bus request is up
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h500;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid.req_up", bus.dmem_req, 1);
    #1 rstn = 1'b0;
    #1 check_idle("rst_mid");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    run_txn("lw_after_rst", 1'b0, 3'd2, 32'h504, 32'h0, 32'hA5A55A5A, 1, 1'b0, 5'd12);

    for (int n = 0; n < 60; n++) begin
      run_txn("rand", 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
              1 + int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), 5'($urandom));
    end

    @(negedge clk);
    check_idle("final");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
